// File: rtl/csa_pipe_if.sv
// Valid/ready operand and result bus for the pipelined carry-select adder.
interface csa_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/csa_pipe.sv
// Two-stage carry-select adder/subtractor: stage 1 precomputes per-block sum pairs,
// stage 2 selects them along the block carry chain. Valid/ready on both sides.
module csa_pipe #(
    parameter int WIDTH = 8,
    parameter int BLK   = 4
) (
    input logic       clk,
    input logic       rst_n,
    csa_pipe_if.slave bus
);

    localparam int BLK_SAFE = (BLK >= 1) ? BLK : 1;
    localparam int NBLK     = WIDTH / BLK_SAFE;

    generate
        if (BLK < 1 || WIDTH < BLK || (WIDTH % BLK_SAFE) != 0) begin : g_bad_params
            $error("csa_pipe: WIDTH must be a multiple of BLK with WIDTH >= BLK >= 1");
        end
    endgenerate

    // ---------------- stage 1: per-block sums for carry-in 0 and 1 ----------------
    logic [WIDTH-1:0]           w_beff;
    logic                       w_c0;
    logic [NBLK-1:0][BLK-1:0]   w_sum0;
    logic [NBLK-1:0][BLK-1:0]   w_sum1;
    logic [NBLK-1:0]            w_co0;
    logic [NBLK-1:0]            w_co1;

    assign w_beff = bus.sub ? ~bus.b : bus.b;
    assign w_c0   = bus.sub | bus.cin;

    generate
        for (genvar g = 0; g < NBLK; g++) begin : g_blk
            assign {w_co0[g], w_sum0[g]} = {1'b0, bus.a[g*BLK +: BLK]}
                                         + {1'b0, w_beff[g*BLK +: BLK]};
            assign {w_co1[g], w_sum1[g]} = {1'b0, bus.a[g*BLK +: BLK]}
                                         + {1'b0, w_beff[g*BLK +: BLK]}
                                         + {{BLK{1'b0}}, 1'b1};
        end
    endgenerate

    logic                       r_s1_valid;
    logic [NBLK-1:0][BLK-1:0]   r_s1_sum0;
    logic [NBLK-1:0][BLK-1:0]   r_s1_sum1;
    logic [NBLK-1:0]            r_s1_co0;
    logic [NBLK-1:0]            r_s1_co1;
    logic                       r_s1_c0;
    logic                       r_s1_a_msb;
    logic                       r_s1_b_msb;

    logic w_s2_adv;
    logic w_in_ready;
    logic r_out_valid;

    assign w_s2_adv   = !r_out_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_ready) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_s1_valid <= bus.in_valid;
        end
    end

    // NOTE: datapath registers carry no reset; the valid flag alone decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (bus.in_valid && w_in_ready) begin
            r_s1_sum0  <= w_sum0;
            r_s1_sum1  <= w_sum1;
            r_s1_co0   <= w_co0;
            r_s1_co1   <= w_co1;
            r_s1_c0    <= w_c0;
            r_s1_a_msb <= bus.a[WIDTH-1];
            r_s1_b_msb <= w_beff[WIDTH-1];
        end
    end

    // ---------------- stage 2: carry-select ripple across blocks ----------------
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    always_comb begin
        logic w_carry;
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_sum   = '0;
        w_carry = r_s1_c0;
        for (int i = 0; i < NBLK; i++) begin
            w_sum[i*BLK +: BLK] = w_carry ? r_s1_sum1[i] : r_s1_sum0[i];
            w_carry             = w_carry ? r_s1_co1[i]  : r_s1_co0[i];
        end
        w_cout = w_carry;
    end

    assign w_ovf = (r_s1_a_msb == r_s1_b_msb) && (w_sum[WIDTH-1] != r_s1_a_msb);

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_csa_pipe.sv
// Directed and randomised checks of csa_pipe: latency, arithmetic corner cases,
// backpressure, mid-operation reset and a 16-bit random run against a reference sum.
module tb_csa_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    csa_pipe_if #(.WIDTH(8))  bus8  ();
    csa_pipe_if #(.WIDTH(16)) bus16 ();

    csa_pipe #(.WIDTH(8),  .BLK(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    csa_pipe #(.WIDTH(16), .BLK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [9:0] exp;   // {cout, ovf, sum}
    } vec8_t;

    vec8_t vt [6] = '{
        '{8'h0F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h10}},
        '{8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h00}},
        '{8'h7F, 8'h00, 1'b0, 1'b1, {1'b0, 1'b1, 8'h80}},
        '{8'h05, 8'h07, 1'b1, 1'b0, {1'b0, 1'b0, 8'hFE}},
        '{8'h80, 8'h01, 1'b1, 1'b0, {1'b1, 1'b1, 8'h7F}},
        '{8'h05, 8'h07, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFE}}
    };

    vec8_t bp [4] = '{
        '{8'h11, 8'h22, 1'b0, 1'b0, {1'b0, 1'b0, 8'h33}},
        '{8'h40, 8'h40, 1'b0, 1'b0, {1'b0, 1'b1, 8'h80}},
        '{8'hF0, 8'h20, 1'b0, 1'b0, {1'b1, 1'b0, 8'h10}},
        '{8'h33, 8'h11, 1'b1, 1'b0, {1'b1, 1'b0, 8'h22}}
    };

    function automatic logic [10:0] got8();
        return {bus8.out_valid, bus8.cout, bus8.ovf, bus8.sum};
    endfunction

    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic sub, input logic cin);
        logic [15:0] be;
        logic [16:0] t;
        logic        v;
        be = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, be} + {16'd0, (sub | cin)};
        v  = (a[15] == be[15]) && (t[15] != a[15]);
        return {t[16], v, t[15:0]};
    endfunction

    task automatic drive8(input vec8_t v, input logic valid);
        bus8.in_valid = valid;
        bus8.a        = v.a;
        bus8.b        = v.b;
        bus8.sub      = v.sub;
        bus8.cin      = v.cin;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (got8() !== 11'd0) begin
            errors++;
            $display("FAIL reset_out8 got %h exp %h", got8(), 11'd0);
        end
        checks++;
        if (bus8.in_ready !== 1'b1 || bus16.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b/%b exp 1/1", bus8.in_ready, bus16.in_ready);
        end
        checks++;
        if (bus16.out_valid !== 1'b0 || bus16.sum !== 16'd0) begin
            errors++;
            $display("FAIL reset_out16 got %b/%h exp 0/0000", bus16.out_valid, bus16.sum);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_ops();
        for (int i = 0; i < 6; i++) begin
            drive8(vt[i], 1'b1);
            @(posedge clk);
            #1;
            bus8.in_valid = 1'b0;
            checks++;
            if (bus8.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL latency_early_%0d got %b exp 0", i, bus8.out_valid);
            end
            @(posedge clk);
            #1;
            checks++;
            if (got8() !== {1'b1, vt[i].exp}) begin
                errors++;
                $display("FAIL single_%0d got %h exp %h", i, got8(), {1'b1, vt[i].exp});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            drive8(vt[k % 4], k < 4);
            checks++;
            if (bus8.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready_%0d got %b exp 1", k, bus8.in_ready);
            end
            @(posedge clk);
            #1;
            if (k >= 1 && k <= 4) begin
                checks++;
                if (got8() !== {1'b1, vt[k-1].exp}) begin
                    errors++;
                    $display("FAIL b2b_%0d got %h exp %h", k - 1, got8(), {1'b1, vt[k-1].exp});
                end
            end else if (k == 5) begin
                checks++;
                if (bus8.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_drain got %b exp 0", bus8.out_valid);
                end
            end
        end
        bus8.in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int  wr = 0;
        int  rd = 0;
        logic acc, con;
        for (int c = 0; c < 12; c++) begin
            if (bus8.out_valid === 1'b1) begin
                checks++;
                if (rd >= 4) begin
                    errors++;
                    $display("FAIL bp_extra got %h exp no result", got8());
                end else if (got8() !== {1'b1, bp[rd].exp}) begin
                    errors++;
                    $display("FAIL bp_result_%0d got %h exp %h", rd, got8(), {1'b1, bp[rd].exp});
                end
            end
            bus8.out_ready = (c >= 6);
            drive8(bp[wr < 4 ? wr : 3], wr < 4);
            #1;
            if (c <= 6) begin
                checks++;
                if (bus8.in_ready !== ((c < 2 || c == 6) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL bp_in_ready_c%0d got %b exp %b", c, bus8.in_ready,
                             (c < 2 || c == 6));
                end
            end
            acc = bus8.in_valid && bus8.in_ready;
            con = bus8.out_valid && bus8.out_ready;
            @(posedge clk);
            #1;
            if (acc) wr++;
            if (con) rd++;
        end
        checks++;
        if (rd != 4 || wr != 4 || bus8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_count got rd=%0d wr=%0d ov=%b exp rd=4 wr=4 ov=0", rd, wr, bus8.out_valid);
        end
        bus8.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus8.out_ready = 1'b1;
        drive8(vt[0], 1'b1);
        @(posedge clk);
        #1;
        drive8(vt[1], 1'b1);
        @(posedge clk);
        #1;
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b0;
        checks++;
        if (bus8.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre got %b exp 1", bus8.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (got8() !== 11'd0 || bus8.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_async got %h/%b exp 000/1", got8(), bus8.in_ready);
        end
        #4 rst_n = 1'b1;
        bus8.out_ready = 1'b1;
        drive8(vt[3], 1'b1);
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        checks++;
        if (bus8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_stale0 got %b exp 0", bus8.out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (got8() !== {1'b1, vt[3].exp}) begin
            errors++;
            $display("FAIL rst_resume got %h exp %h", got8(), {1'b1, vt[3].exp});
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus8.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_stale_%0d got %b exp 0", c, bus8.out_valid);
            end
        end
    endtask

    task automatic test_random16();
        logic [17:0] q [$];
        int          rd = 0;
        int          cyc = 0;
        logic        acc, con;
        while (rd < 10000 && cyc < 60000) begin
            bus16.in_valid  = ($urandom_range(0, 3) != 0);
            bus16.out_ready = $urandom_range(0, 1);
            bus16.a         = 16'($urandom);
            bus16.b         = 16'($urandom);
            bus16.sub       = $urandom_range(0, 1);
            bus16.cin       = $urandom_range(0, 1);
            #1;
            acc = bus16.in_valid && bus16.in_ready;
            con = bus16.out_valid && bus16.out_ready;
            if (con) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra got %h exp no result", bus16.sum);
                end else if ({bus16.cout, bus16.ovf, bus16.sum} !== q[0]) begin
                    errors++;
                    $display("FAIL rnd_%0d got %h exp %h", rd,
                             {bus16.cout, bus16.ovf, bus16.sum}, q[0]);
                end
            end
            if (acc) q.push_back(model16(bus16.a, bus16.b, bus16.sub, bus16.cin));
            @(posedge clk);
            #1;
            if (con) begin
                if (q.size() != 0) void'(q.pop_front());
                rd++;
            end
            cyc++;
        end
        bus16.in_valid = 1'b0;
        checks++;
        if (rd < 10000) begin
            errors++;
            $display("FAIL rnd_timeout got %0d exp 10000", rd);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus8.in_valid   = 1'b0;
        bus8.a          = '0;
        bus8.b          = '0;
        bus8.sub        = 1'b0;
        bus8.cin        = 1'b0;
        bus8.out_ready  = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.sub       = 1'b0;
        bus16.cin       = 1'b0;
        bus16.out_ready = 1'b1;

        test_reset();
        test_single_ops();
        test_back_to_back();
        @(posedge clk);
        #1;
        test_backpressure();
        test_reset_mid();
        test_random16();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
